// File: rtl/ad79x8_sequencer_pkg.sv
// Shared definitions for the AD79x8 channel sequencer: control-word layout,
// power-up constants and the sequencer FSM state encoding.
package ad79x8_sequencer_pkg;

    localparam int NUM_CH       = 8;
    localparam int BIT_WRITE    = 15;
    localparam int BIT_SEQ      = 14;
    localparam int BIT_ADDR_LSB = 10;
    localparam int BIT_PM_LSB   = 8;
    localparam int BIT_SHADOW   = 7;
    localparam int BIT_RANGE    = 5;
    localparam int BIT_CODING   = 4;

    localparam logic       WRITE_EN     = 1'b1;
    localparam logic       SEQ_OFF      = 1'b0;
    localparam logic [1:0] PM_NORMAL    = 2'b11;
    localparam logic [15:0] DUMMY_WORD  = 16'hFFFF;
    localparam int         DUMMY_FRAMES = 2;

    typedef enum logic [2:0] {
        ST_DUMMY     = 3'd0,
        ST_IDLE      = 3'd1,
        ST_ISSUE     = 3'd2,
        ST_WAIT_BUSY = 3'd3,
        ST_WAIT_DONE = 3'd4,
        ST_PARSE     = 3'd5
    } state_t;

    function automatic logic [15:0] ctrl_word(input logic [2:0] ch,
                                              input logic range_bit,
                                              input logic coding_bit);
        logic [15:0] w;
        w                   = '0;
        w[BIT_WRITE]        = WRITE_EN;
        w[BIT_SEQ]          = SEQ_OFF;
        w[BIT_ADDR_LSB +: 3] = ch;
        w[BIT_PM_LSB +: 2]  = PM_NORMAL;
        w[BIT_SHADOW]       = 1'b0;
        w[BIT_RANGE]        = range_bit;
        w[BIT_CODING]       = coding_bit;
        return w;
    endfunction

endpackage

// File: rtl/ad79x8_sequencer_ch_next.sv
// Next channel in the scan list: the next set bit of the mask above cur_ch,
// wrapping 7 -> 0. An empty mask behaves as channel 0 only.
module ad79x8_sequencer_ch_next
    import ad79x8_sequencer_pkg::*;
(
    input  logic [7:0] ch_mask,
    input  logic [2:0] cur_ch,
    output logic [2:0] next_ch
);

    logic [7:0] mask;
    logic [2:0] idx;

    // Walk offsets from farthest to nearest so the nearest set bit wins;
    // offset NUM_CH lands back on cur_ch itself for a single-channel list.
    always_comb begin
        mask    = (ch_mask == 8'h00) ? 8'h01 : ch_mask;
        next_ch = cur_ch;
        idx     = cur_ch;
        for (int k = NUM_CH; k >= 1; k--) begin
            idx = cur_ch + 3'(k);
            if (mask[idx]) next_ch = idx;
        end
    end

endmodule

// File: rtl/ad79x8_sequencer.sv
// Channel sequencer and result parser for the AD7908/AD7918/AD7928 SPI engine.
// Handshake: a sample transfers on any clk edge where m_valid and m_ready are both 1.
module ad79x8_sequencer
    import ad79x8_sequencer_pkg::*;
#(
    parameter logic [7:0] CH_MASK    = 8'hFF,
    parameter int         RESOLUTION = 12,
    parameter logic       RANGE_BIT  = 1'b1,
    parameter logic       CODING_BIT = 1'b1,
    parameter int         PERIOD     = 400,
    parameter int         TIMEOUT    = 1023
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    output logic                  spi_initiate,
    output logic [15:0]           spi_word,
    input  logic                  spi_ready,
    input  logic [15:0]           spi_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [2:0]            m_channel,
    output logic [RESOLUTION-1:0] m_code,
    output logic                  overrun,
    output logic                  ch_error,
    output logic                  timeout_err,
    output logic [2:0]            dbg_state
);

    state_t      state, state_nxt;
    logic [15:0] period_cnt;
    logic [15:0] to_cnt;
    logic [1:0]  dummy_cnt;
    logic        pipe_valid;
    logic [2:0]  next_ch, prev_ch, adv_ch, first_ch;
    logic        in_dummy, period_done, waiting, timed_out;
    logic [2:0]  rx_addr;
    logic [RESOLUTION-1:0] rx_code;
    logic        unused_data;

    ad79x8_sequencer_ch_next u_ch_adv   (.ch_mask(CH_MASK), .cur_ch(next_ch), .next_ch(adv_ch));
    ad79x8_sequencer_ch_next u_ch_first (.ch_mask(CH_MASK), .cur_ch(3'd7),    .next_ch(first_ch));

    assign in_dummy    = (dummy_cnt != 2'(DUMMY_FRAMES));
    // Reaching 1 (not 0) lets the IDLE->ISSUE step land exactly PERIOD cycles after the last start.
    assign period_done = (period_cnt <= 16'd1);
    assign waiting     = (state == ST_WAIT_BUSY) || (state == ST_WAIT_DONE);
    assign timed_out   = waiting && (to_cnt == 16'(TIMEOUT - 1));
    assign rx_addr     = spi_data[14:12];
    assign rx_code     = spi_data[11 -: RESOLUTION];
    assign unused_data = ^spi_data;
    assign dbg_state   = state;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_DUMMY:     if (period_done && spi_ready) state_nxt = ST_ISSUE;
            ST_IDLE:      if (enable && period_done) state_nxt = ST_ISSUE;
            ST_ISSUE:     state_nxt = ST_WAIT_BUSY;
            ST_WAIT_BUSY: if (timed_out) state_nxt = ST_IDLE;
                          else if (!spi_ready) state_nxt = ST_WAIT_DONE;
            ST_WAIT_DONE: if (timed_out) state_nxt = ST_IDLE;
                          else if (spi_ready) state_nxt = ST_PARSE;
            ST_PARSE:     if (in_dummy && (dummy_cnt != 2'(DUMMY_FRAMES - 1))) state_nxt = ST_DUMMY;
                          else state_nxt = ST_IDLE;
            default:      state_nxt = ST_DUMMY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_DUMMY;
            period_cnt   <= '0;
            to_cnt       <= '0;
            dummy_cnt    <= '0;
            pipe_valid   <= 1'b0;
            next_ch      <= first_ch;
            prev_ch      <= first_ch;
            spi_initiate <= 1'b0;
            spi_word     <= DUMMY_WORD;
            m_valid      <= 1'b0;
            m_channel    <= '0;
            m_code       <= '0;
            overrun      <= 1'b0;
            ch_error     <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            state        <= state_nxt;
            spi_initiate <= (state_nxt == ST_ISSUE);
            if (state_nxt == ST_ISSUE)
                spi_word <= in_dummy ? DUMMY_WORD : ctrl_word(next_ch, RANGE_BIT, CODING_BIT);

            if (state == ST_ISSUE) period_cnt <= 16'(PERIOD - 1);
            else if (period_cnt != 16'd0) period_cnt <= period_cnt - 16'd1;

            to_cnt <= waiting ? to_cnt + 16'd1 : 16'd0;
            if (timed_out) begin
                timeout_err <= 1'b1;
                pipe_valid  <= 1'b0;
                if (in_dummy) dummy_cnt <= 2'(DUMMY_FRAMES);
            end

            if (m_valid && m_ready) m_valid <= 1'b0;

            if (state == ST_PARSE) begin
                if (in_dummy) begin
                    dummy_cnt <= dummy_cnt + 2'd1;
                end else begin
                    // This frame carries the conversion requested by the previous word.
                    if (pipe_valid) begin
                        if (rx_addr != prev_ch) ch_error <= 1'b1;
                        if (!m_valid || m_ready) begin
                            m_valid   <= 1'b1;
                            m_channel <= rx_addr;
                            m_code    <= rx_code;
                        end else begin
                            overrun <= 1'b1;
                        end
                    end
                    pipe_valid <= 1'b1;
                    prev_ch    <= next_ch;
                    next_ch    <= adv_ch;
                end
            end
        end
    end

endmodule
